// File: rtl/paddle_box_tracker_pkg.sv
// Shared definitions for the paddle tracker, ball and overlay logic.
package paddle_box_tracker_pkg;

    // Coordinate width for rows, columns and box outputs
    localparam int unsigned COORD_W = 13;

    // Empty box: top/left above bottom/right so no collision can occur
    localparam logic [COORD_W-1:0] EMPTY_TOP   = '1;
    localparam logic [COORD_W-1:0] EMPTY_LEFT  = '1;
    localparam logic [COORD_W-1:0] EMPTY_BOT   = '0;
    localparam logic [COORD_W-1:0] EMPTY_RIGHT = '0;

    // Horizontal run counter width and saturation value
    localparam int unsigned RUN_W   = 4;
    localparam int unsigned RUN_SAT = 15;

    typedef enum logic {
        ALIGN,
        ACCUM
    } state_e;

endpackage

// File: rtl/paddle_box_tracker_run_qualifier.sv
// Horizontal run tracker: flags mask pixels that belong to a run of at
// least RUN_MIN consecutive columns on one row.
module run_qualifier
    import paddle_box_tracker_pkg::*;
#(
    parameter int unsigned W       = COORD_W,
    parameter int unsigned RUN_MIN = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en_i,
    input  logic         clear_i,
    input  logic         mask_i,
    input  logic [W-1:0] row_i,
    input  logic [W-1:0] col_i,
    output logic         qualify_o,
    output logic         first_qual_o
);

    logic [W-1:0]     prev_row_q, prev_row_d;
    logic [W-1:0]     prev_col_q, prev_col_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [RUN_W-1:0] run_next;
    logic             cont;

    // Run update for the current pixel and next-state of the tracker
    always_comb begin
        // Adjacency check done one bit wider so an all-ones prev_col never
        // wraps onto column 0
        cont = mask_i && (row_i == prev_row_q) &&
               ({1'b0, col_i} == ({1'b0, prev_col_q} + (W+1)'(1)));
        if (cont) begin
            run_next = (run_q == RUN_W'(RUN_SAT)) ? run_q : run_q + 1'b1;
        end else begin
            run_next = mask_i ? RUN_W'(1) : '0;
        end

        qualify_o    = en_i && mask_i && (run_next >= RUN_W'(RUN_MIN));
        // A saturated run that stays at RUN_MIN is not a fresh crossing
        first_qual_o = qualify_o && (run_next == RUN_W'(RUN_MIN)) &&
                       !(cont && (run_q == RUN_W'(RUN_MIN)));

        prev_row_d = prev_row_q;
        prev_col_d = prev_col_q;
        run_d      = run_q;
        if (en_i) begin
            prev_row_d = row_i;
            prev_col_d = col_i;
            run_d      = run_next;
        end
        if (clear_i) begin
            prev_col_d = '1;
            run_d      = '0;
        end
    end

    // Tracker state registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_row_q <= '0;
            prev_col_q <= '1;
            run_q      <= '0;
        end else begin
            prev_row_q <= prev_row_d;
            prev_col_q <= prev_col_d;
            run_q      <= run_d;
        end
    end

endmodule

// File: rtl/paddle_box_tracker.sv
// Paddle bounding-box tracker: accumulates the extent of qualified mask
// pixels per frame and publishes it with a sync pulse at frame end.
module paddle_box_tracker
    import paddle_box_tracker_pkg::*;
#(
    parameter int unsigned W          = COORD_W,
    parameter int unsigned RUN_MIN    = 3,
    parameter int unsigned MIN_PIXELS = 16,
    parameter int unsigned CNT_W      = 20
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         pix_valid,
    input  logic [W-1:0] pix_row,
    input  logic [W-1:0] pix_col,
    input  logic         mask,
    input  logic         frame_end,
    output logic [W-1:0] T,
    output logic [W-1:0] B,
    output logic [W-1:0] L,
    output logic [W-1:0] R,
    output logic         box_valid,
    output logic         sync
);

    state_e state_q, state_d;

    logic [W-1:0]     min_row_q, min_row_d, min_row_w;
    logic [W-1:0]     max_row_q, max_row_d, max_row_w;
    logic [W-1:0]     min_col_q, min_col_d, min_col_w;
    logic [W-1:0]     max_col_q, max_col_d, max_col_w;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_w;
    logic [W-1:0]     t_q, t_d, b_q, b_d, l_q, l_d, r_q, r_d;
    logic             valid_q, valid_d;
    logic             sync_q, sync_d;

    logic             accept;
    logic             qualify;
    logic             first_qual;
    logic [W-1:0]     run_start;
    logic [CNT_W-1:0] inc;
    logic [CNT_W:0]   sum;

    assign accept = (state_q == ACCUM) && pix_valid;

    run_qualifier #(
        .W       (W),
        .RUN_MIN (RUN_MIN)
    ) u_run_qualifier (
        .clk          (clk),
        .reset_n      (reset_n),
        .en_i         (accept),
        .clear_i      (frame_end),
        .mask_i       (mask),
        .row_i        (pix_row),
        .col_i        (pix_col),
        .qualify_o    (qualify),
        .first_qual_o (first_qual)
    );

    // Accumulator values including the current pixel, so a pixel arriving
    // together with frame_end is part of the published box
    always_comb begin
        min_row_w = min_row_q;
        max_row_w = max_row_q;
        min_col_w = min_col_q;
        max_col_w = max_col_q;
        cnt_w     = cnt_q;
        run_start = pix_col - W'(RUN_MIN - 1);
        inc       = first_qual ? CNT_W'(RUN_MIN) : CNT_W'(1);
        sum       = {1'b0, cnt_q} + {1'b0, inc};
        if (qualify) begin
            if (pix_row < min_row_q) min_row_w = pix_row;
            if (pix_row > max_row_q) max_row_w = pix_row;
            if (pix_col > max_col_q) max_col_w = pix_col;
            cnt_w = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
            if (first_qual && (run_start < min_col_q)) min_col_w = run_start;
        end
    end

    // Frame FSM: alignment, accumulation and publish
    always_comb begin
        state_d   = state_q;
        min_row_d = min_row_w;
        max_row_d = max_row_w;
        min_col_d = min_col_w;
        max_col_d = max_col_w;
        cnt_d     = cnt_w;
        t_d       = t_q;
        b_d       = b_q;
        l_d       = l_q;
        r_d       = r_q;
        valid_d   = valid_q;
        sync_d    = 1'b0;

        if (frame_end) begin
            if (state_q == ACCUM) begin
                sync_d = 1'b1;
                if (cnt_w >= CNT_W'(MIN_PIXELS)) begin
                    t_d     = min_row_w;
                    b_d     = max_row_w;
                    l_d     = min_col_w;
                    r_d     = max_col_w;
                    valid_d = 1'b1;
                end else begin
                    t_d     = EMPTY_TOP;
                    b_d     = EMPTY_BOT;
                    l_d     = EMPTY_LEFT;
                    r_d     = EMPTY_RIGHT;
                    valid_d = 1'b0;
                end
            end
            state_d   = ACCUM;
            min_row_d = EMPTY_TOP;
            max_row_d = EMPTY_BOT;
            min_col_d = EMPTY_LEFT;
            max_col_d = EMPTY_RIGHT;
            cnt_d     = '0;
        end
    end

    // State, accumulator and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ALIGN;
            min_row_q <= EMPTY_TOP;
            max_row_q <= EMPTY_BOT;
            min_col_q <= EMPTY_LEFT;
            max_col_q <= EMPTY_RIGHT;
            cnt_q     <= '0;
            t_q       <= EMPTY_TOP;
            b_q       <= EMPTY_BOT;
            l_q       <= EMPTY_LEFT;
            r_q       <= EMPTY_RIGHT;
            valid_q   <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_row_q <= min_row_d;
            max_row_q <= max_row_d;
            min_col_q <= min_col_d;
            max_col_q <= max_col_d;
            cnt_q     <= cnt_d;
            t_q       <= t_d;
            b_q       <= b_d;
            l_q       <= l_d;
            r_q       <= r_d;
            valid_q   <= valid_d;
            sync_q    <= sync_d;
        end
    end

    assign T         = t_q;
    assign B         = b_q;
    assign L         = l_q;
    assign R         = r_q;
    assign box_valid = valid_q;
    assign sync      = sync_q;

endmodule

// File: tb/tb_paddle_box_tracker.sv
// Self-checking bench for paddle_box_tracker using a frame-level model.
module tb_paddle_box_tracker;

    localparam int RUN_MIN    = 3;
    localparam int MIN_PIXELS = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pix_valid;
    logic [12:0] pix_row;
    logic [12:0] pix_col;
    logic        mask;
    logic        frame_end;
    logic [12:0] T, B, L, R;
    logic        box_valid;
    logic        sync;

    always #5 clk = ~clk;

    paddle_box_tracker #(
        .W          (13),
        .RUN_MIN    (RUN_MIN),
        .MIN_PIXELS (MIN_PIXELS),
        .CNT_W      (20)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pix_valid (pix_valid),
        .pix_row   (pix_row),
        .pix_col   (pix_col),
        .mask      (mask),
        .frame_end (frame_end),
        .T         (T),
        .B         (B),
        .L         (L),
        .R         (R),
        .box_valid (box_valid),
        .sync      (sync)
    );

    typedef struct {
        int row;
        int col;
        bit m;
    } pix_t;

    pix_t frame_q[$];
    int   exp_T = 8191, exp_B = 0, exp_L = 8191, exp_R = 0;
    bit   exp_valid = 1'b0, exp_sync = 1'b0;
    bit   aligned = 1'b0;
    bit   chk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Box of a frame: split the pixel list into maximal horizontal runs and
    // keep every run at least RUN_MIN long
    task automatic publish_model();
        int i, j, n, cnt;
        int tmin, tmax, lmin, rmax;
        n = frame_q.size();
        cnt = 0; tmin = 8191; tmax = 0; lmin = 8191; rmax = 0;
        i = 0;
        while (i < n) begin
            if (!frame_q[i].m) begin
                i++;
            end else begin
                j = i;
                while (j + 1 < n && frame_q[j+1].m &&
                       frame_q[j+1].row == frame_q[j].row &&
                       frame_q[j+1].col == frame_q[j].col + 1)
                    j++;
                if (j - i + 1 >= RUN_MIN) begin
                    cnt += j - i + 1;
                    if (frame_q[i].row < tmin) tmin = frame_q[i].row;
                    if (frame_q[i].row > tmax) tmax = frame_q[i].row;
                    if (frame_q[i].col < lmin) lmin = frame_q[i].col;
                    if (frame_q[j].col > rmax) rmax = frame_q[j].col;
                end
                i = j + 1;
            end
        end
        if (cnt >= MIN_PIXELS) begin
            exp_T = tmin; exp_B = tmax; exp_L = lmin; exp_R = rmax; exp_valid = 1'b1;
        end else begin
            exp_T = 8191; exp_B = 0; exp_L = 8191; exp_R = 0; exp_valid = 1'b0;
        end
    endtask

    // Effect of one clock edge on the expected outputs
    task automatic model_edge();
        pix_t p;
        exp_sync = 1'b0;
        if (!reset_n) begin
            exp_T = 8191; exp_B = 0; exp_L = 8191; exp_R = 0; exp_valid = 1'b0;
            aligned = 1'b0;
            frame_q.delete();
        end else if (!aligned) begin
            if (frame_end) begin
                aligned = 1'b1;
                frame_q.delete();
            end
        end else begin
            if (pix_valid) begin
                p.row = int'(pix_row);
                p.col = int'(pix_col);
                p.m   = mask;
                frame_q.push_back(p);
            end
            if (frame_end) begin
                publish_model();
                exp_sync = 1'b1;
                frame_q.delete();
            end
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("T", int'(T), exp_T);
            check("B", int'(B), exp_B);
            check("L", int'(L), exp_L);
            check("R", int'(R), exp_R);
            check("box_valid", int'(box_valid), int'(exp_valid));
            check("sync", int'(sync), int'(exp_sync));
        end
    end

    task automatic drive(input bit v, input int r, input int c, input bit m, input bit fe);
        pix_valid = v;
        pix_row   = 13'(r);
        pix_col   = 13'(c);
        mask      = m;
        frame_end = fe;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic block(input int r0, input int nrows, input int c0, input int ncols);
        for (int r = r0; r < r0 + nrows; r++)
            for (int c = c0; c < c0 + ncols; c++)
                drive(1'b1, r, c, 1'b1, 1'b0);
    endtask

    task automatic fe_pulse();
        drive(1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic check_box(input string tag, input int t, input int b, input int l,
                             input int r, input int v, input int s);
        check({tag, "_T"}, int'(T), t);
        check({tag, "_B"}, int'(B), b);
        check({tag, "_L"}, int'(L), l);
        check({tag, "_R"}, int'(R), r);
        check({tag, "_valid"}, int'(box_valid), v);
        check({tag, "_sync"}, int'(sync), s);
    endtask

    initial begin
        reset_n = 1'b0;
        pix_valid = 1'b0; pix_row = '0; pix_col = '0; mask = 1'b0; frame_end = 1'b0;
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        chk_en = 1'b1;
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        check_box("reset", 8191, 0, 8191, 0, 0, 0);
        reset_n = 1'b1;

        // First frame_end only aligns
        idle(2);
        block(3, 6, 3, 6);
        fe_pulse();
        check_box("align", 8191, 0, 8191, 0, 0, 0);

        // Solid paddle with a stall in the middle of each row
        for (int r = 100; r < 110; r++)
            for (int c = 200; c < 220; c++) begin
                if (c == 210) idle(1);
                drive(1'b1, r, c, 1'b1, 1'b0);
            end
        fe_pulse();
        check_box("paddle", 100, 109, 200, 219, 1, 1);
        idle(1);
        check("sync_one_cycle", int'(sync), 0);

        // Runs of two are noise
        for (int r = 200; r < 220; r++) begin
            drive(1'b1, r, 50, 1'b1, 1'b0);
            drive(1'b1, r, 51, 1'b1, 1'b0);
            drive(1'b1, r, 52, 1'b0, 1'b0);
        end
        fe_pulse();
        check_box("noise", 8191, 0, 8191, 0, 0, 1);

        // Twelve qualified pixels, then eighteen
        block(30, 4, 10, 3);
        fe_pulse();
        check_box("px12", 8191, 0, 8191, 0, 0, 1);
        block(30, 6, 10, 3);
        fe_pulse();
        check_box("px18", 30, 35, 10, 12, 1, 1);

        // Last pixel of a run arrives with frame_end
        block(100, 5, 200, 20);
        drive(1'b1, 479, 628, 1'b1, 1'b0);
        drive(1'b1, 479, 629, 1'b1, 1'b0);
        drive(1'b1, 479, 630, 1'b1, 1'b1);
        check_box("coinc", 100, 479, 200, 630, 1, 1);

        // Run starting at column 0, then back-to-back frame_end
        block(5, 6, 0, 3);
        fe_pulse();
        check_box("col0", 5, 10, 0, 2, 1, 1);
        fe_pulse();
        check_box("b2b", 8191, 0, 8191, 0, 0, 1);

        // Reset mid-frame discards the partial frame and realigns
        block(100, 5, 200, 20);
        reset_n = 1'b0;
        drive(1'b1, 105, 200, 1'b1, 1'b0);
        reset_n = 1'b1;
        check_box("midrst", 8191, 0, 8191, 0, 0, 0);
        block(100, 2, 200, 20);
        fe_pulse();
        check_box("realign", 8191, 0, 8191, 0, 0, 0);
        block(7, 6, 300, 3);
        fe_pulse();
        check_box("after_rst", 7, 12, 300, 302, 1, 1);
        idle(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/paddle_box_tracker.md
Name: paddle_box_tracker

Overview:
- Produces the paddle bounding box (T, B, L, R) that the ball collision logic consumes, plus a once-per-frame sync pulse.
- Scans the HSV-thresholded, denoised mask pixel stream for each frame and accumulates min/max row and column of qualified mask pixels.
- Publishes the box at end of frame, and only if enough pixels qualified.
- Sits between the HSV mask/denoise pipeline and the ball module.

Parameters:
- W, 13, coordinate width for rows, columns and box outputs.
- RUN_MIN, 3, consecutive mask pixels on one row needed before pixels qualify (horizontal denoise); legal range 1..15.
- MIN_PIXELS, 16, qualified-pixel count needed for a frame's box to be valid.
- CNT_W, 20, width of the qualified-pixel counter; counter saturates at all-ones.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- pix_valid  in  1  current pixel fields valid this cycle.
- pix_row  in  W  row of current pixel.
- pix_col  in  W  column of current pixel.
- mask  in  1  pixel passed HSV threshold/denoise.
- frame_end  in  1  one-cycle pulse after the last pixel of a frame.
- T  out  W  published top row.
- B  out  W  published bottom row.
- L  out  W  published left column.
- R  out  W  published right column.
- box_valid  out  1  published box came from a frame with ≥MIN_PIXELS qualified pixels.
- sync  out  1  one-cycle pulse when T/B/L/R are updated; drives the ball module's sync.

Behaviour:
- Empty box constant: T=L=all-ones (8191), B=R=0. With T>B and L>R the ball module sees no collision.
- Reset (reset_n=0 at a clock edge):
  - outputs go to the empty box; box_valid=0; sync=0.
  - accumulators go to empty; run counter=0; count=0; FSM=ALIGN.
  - a reset mid-frame discards all partial data.
- FSM state ALIGN: pixels are ignored. On frame_end go to ACCUM with accumulators cleared. No publish and no sync on this first frame_end.
- FSM state ACCUM: accumulate pixels. On frame_end, publish, clear, and stay in ACCUM.
- Run tracking (ACCUM, pix_valid=1):
  - if mask=1 and pix_row==prev_row and pix_col==prev_col+1, then run = min(run+1, 15); else run = mask ? 1 : 0.
  - prev_row and prev_col are updated on every valid pixel.
  - pix_valid=0 cycles leave all state unchanged (stalls are transparent).
- Qualification: a pixel qualifies when mask=1 and run (after update) ≥ RUN_MIN.
  - On the pixel where run first equals RUN_MIN: min_col ← min(min_col, pix_col−(RUN_MIN−1)), and count += RUN_MIN (saturating).
  - On later qualifying pixels: count += 1 (saturating).
  - All qualifying pixels: max_col ← max(max_col, pix_col); min_row ← min(min_row, pix_row); max_row ← max(max_row, pix_row).
- Publish (frame_end=1 in ACCUM at cycle n):
  - If pix_valid is also 1 in cycle n, that pixel is included before the compare.
  - At edge n+1: if count ≥ MIN_PIXELS, T=min_row, B=max_row, L=min_col, R=max_col, box_valid=1. Otherwise output the empty box, box_valid=0.
  - sync=1 for exactly the cycle after edge n+1; outputs hold until the next publish.
  - Accumulators, run and count are cleared at the same edge; prev_col is set to all-ones so the first pixel of the next frame starts a new run.
- Arithmetic: all comparisons unsigned W-bit; pix_col−(RUN_MIN−1) never underflows, because a run of RUN_MIN ends at col ≥ RUN_MIN−1. Count saturates and never wraps.
- frame_end asserted in back-to-back cycles: the second publishes an empty frame (box_valid=0).

Decomposition:
- Shared package gets:
  - the coordinate width W = 13;
  - the EMPTY_TOP/LEFT (all-ones) and EMPTY_BOT/RIGHT (0) constants, also used by ball and overlay drawing;
  - the FSM state enum {ALIGN, ACCUM}.
- One natural sub-module, run_qualifier: owns prev_row, prev_col and the run counter, and outputs qualify plus first_qual. The top module keeps the min/max accumulators, the counter, the FSM and the output registers.

Test Plan:
- Reset, then one frame_end → no sync pulse; T=8191, B=0, L=8191, R=0, box_valid=0.
- After alignment, mask=1 on rows 100..109, cols 200..219 (200 pixels), then frame_end → next cycle sync=1, T=100, B=109, L=200, R=219, box_valid=1.
- Isolated noise: mask=1 on runs of 2 pixels (cols 50–51) on 20 rows, then frame_end → empty box, box_valid=0, sync=1.
- 12 qualified pixels only (4 rows × 3-pixel runs, MIN_PIXELS=16), then frame_end → empty box, box_valid=0. Repeat with 6 rows (18 pixels) → valid box.
- frame_end coincident with a valid pixel at row 479, col 630 that completes a run (cols 628–630), on top of an existing box → B=479, R=630 are included in the published box.
- Assert reset_n=0 mid-frame after 100 qualified pixels → outputs return to the empty box and FSM=ALIGN; the following frame_end does not pulse sync.
